display_link_arbiter: RTL and testbench
=======================================

DISPLAY_LINK_ARBITER -- requirements
Module: display_link_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing the display link.
REQ-002 The block SHALL have parameter AW, default 8, meaning the register address width.
REQ-003 The block SHALL have parameter DW, default 32, meaning the register data width.
REQ-004 The block SHALL have parameter TIMEOUT, default 255, meaning the number of read-wait cycles before a read is abandoned.
REQ-005 The block SHALL have port c125  in  1  the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset  in  1  synchronous, active-low reset.
REQ-007 The block SHALL have ports req_valid/req_write  in  NREQ each  per-requester request and direction (1 = write).
REQ-008 The block SHALL have ports req_addr  in  NREQ*AW  and  req_wdata  in  NREQ*DW  packed per requester, index 0 in the LSBs.
REQ-009 The block SHALL have port req_ready  out  NREQ  one-hot, one-cycle pulse when that request is accepted.
REQ-010 The block SHALL have ports rsp_valid  out  NREQ  (one-hot completion pulse), rsp_rdata  out  DW  and rsp_timeout  out  1.
REQ-011 The block SHALL have ports link_valid/link_write  out  1, link_addr  out  AW, link_wdata  out  DW, link_ready  in  1: the command handshake to the host serializer.
REQ-012 The block SHALL have ports link_rvalid  in  1 and link_rdata  in  DW (read return), plus busy  out  1 (state != IDLE).

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_RD and RESP.
REQ-014 In IDLE, when any req_valid is set, the block SHALL grant round-robin, searching from rr_ptr upward with wrap, pulse req_ready for the winner, capture its write/addr/wdata and index, and go to ISSUE.
REQ-015 On grant, rr_ptr SHALL become (winner+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-016 In ISSUE, link_valid SHALL be 1 with the captured fields held stable until the cycle link_ready=1.
REQ-017 On the ISSUE handshake, a write SHALL go to RESP and a read SHALL go to WAIT_RD with the timeout counter cleared to 0.
REQ-018 In WAIT_RD, the counter SHALL increment each cycle; link_rvalid=1 SHALL capture link_rdata, and count reaching TIMEOUT without it SHALL set the timeout flag and rdata to all-ones; either event goes to RESP.
REQ-019 If link_rvalid and the timeout occur in the same cycle, the data SHALL win and rsp_timeout SHALL be 0.
REQ-020 link_rvalid outside WAIT_RD SHALL be ignored.
REQ-021 In RESP, the block SHALL pulse rsp_valid[captured index] for exactly one cycle with rsp_rdata and rsp_timeout driven (rdata=0 for writes), then return to IDLE.
REQ-022 Minimum write latency SHALL be: accept at cycle 0, link_valid at cycle 1, rsp_valid at cycle 2 with link_ready=1 at cycle 1, and next accept possible at cycle 3.
REQ-023 Only one transaction SHALL be outstanding; req_valid is sampled only in IDLE, and dropping req_valid before grant SHALL have no effect.
REQ-024 rsp_rdata and rsp_timeout SHALL be 0 whenever rsp_valid is all-zero.

Reset
REQ-025 When reset=0 at a c125 edge, the block SHALL enter IDLE, set rr_ptr=0, clear the counter, and drive req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, link_valid=0, link_write=0, link_addr=0, link_wdata=0 and busy=0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no rsp_valid ever issued for it.

Structure
REQ-027 Package display_pkg SHALL hold the state encoding and the TIMEOUT and DW defaults shared with display_host.
REQ-028 The round-robin winner search SHALL be a combinational sub-module display_rr_pick(NREQ), with inputs req and ptr and outputs onehot and index.

Verification
REQ-029 The bench SHALL cover a single write: req 2 writes addr 0x10, data 0xDEADBEEF with link_ready=1 -> req_ready[2] at cycle 0, link fields match at cycle 1, rsp_valid=4'b0100 at cycle 2.
REQ-030 The bench SHALL cover round-robin: all four requesting continuously -> grant order 0,1,2,3,0 and never the same requester twice in a row.
REQ-031 The bench SHALL cover a read: req 1 reads 0x20, link_rvalid with 0x12345678 after 5 cycles -> rsp_valid=4'b0010, rsp_rdata=0x12345678, rsp_timeout=0.
REQ-032 The bench SHALL cover a read timeout: no link_rvalid -> rsp after exactly TIMEOUT=255 WAIT_RD cycles with rsp_timeout=1 and rdata=0xFFFFFFFF.
REQ-033 The bench SHALL cover backpressure: link_ready held 0 for 10 cycles -> link_valid and its fields stable throughout, and no rsp_valid.
REQ-034 The bench SHALL cover reset in WAIT_RD: reset=0 for 1 cycle -> all outputs 0 and rr_ptr=0 the next cycle, and no rsp for the aborted read.

Source files
------------

// File: rtl/display_pkg.sv
// ---------------------------------------------------------------------------
// display_pkg
// Shared definitions for the display link blocks (display_link_arbiter and
// display_host). Holds the link FSM state encoding, the default data width
// and read timeout, and the width helpers used to size counters and
// requester indices.
// ---------------------------------------------------------------------------
package display_pkg;

    // Defaults shared with display_host.
    localparam int DISPLAY_DW      = 32;
    localparam int DISPLAY_TIMEOUT = 255;

    // Link transaction FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2,
        ST_RESP    = 2'd3
    } link_state_e;

    // Bits needed to index n requesters (at least one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to count from 0 up to limit inclusive.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/display_rr_pick.sv
// ---------------------------------------------------------------------------
// display_rr_pick
// Combinational round-robin winner search. Starting at ptr and moving upward
// with wrap-around, picks the first requester whose req bit is set.
//
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IW    highest-priority requester for this search
//   onehot out NREQ  one-hot winner (all-zero when req is all-zero)
//   index  out IW    binary index of the winner (0 when no winner)
// ---------------------------------------------------------------------------
module display_rr_pick
    import display_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int IW  = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   index
);

    logic found;

    // Two passes replace a modulo rotation: first the upper segment
    // [ptr, NREQ-1], then the wrapped segment [0, ptr-1].
    always_comb begin
        // NOTE: every output gets a default before the search so no path
        // leaves it unassigned, which would otherwise infer a latch.
        onehot = '0;
        index  = '0;
        found  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                index     = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                found     = 1'b1;
                onehot[i] = 1'b1;
                index     = IW'(i);
            end
        end
    end

endmodule

// File: rtl/display_link_arbiter.sv
// ---------------------------------------------------------------------------
// display_link_arbiter
// Shares one register-access link to the host serializer between NREQ
// requesters. One transaction is outstanding at a time: a round-robin grant
// in IDLE, the command handshake in ISSUE, a bounded wait for read data in
// WAIT_RD, and a one-cycle completion pulse in RESP.
//
// Ports:
//   c125           in   1        clock, rising edge
//   reset          in   1        synchronous, active-low
//   req_valid      in   NREQ     per-requester request
//   req_write      in   NREQ     per-requester direction (1 = write)
//   req_addr       in   NREQ*AW  per-requester address, requester 0 in LSBs
//   req_wdata      in   NREQ*DW  per-requester write data, requester 0 in LSBs
//   req_ready      out  NREQ     one-hot accept pulse
//   rsp_valid      out  NREQ     one-hot completion pulse
//   rsp_rdata      out  DW       read data (0 for writes and when idle)
//   rsp_timeout    out  1        read abandoned after TIMEOUT wait cycles
//   link_valid     out  1        command valid towards the serializer
//   link_write     out  1        command direction
//   link_addr      out  AW       command address
//   link_wdata     out  DW       command write data
//   link_ready     in   1        serializer accepts the command
//   link_rvalid    in   1        read data return strobe
//   link_rdata     in   DW       read data return
//   busy           out  1        a transaction is in progress
// ---------------------------------------------------------------------------
module display_link_arbiter
    import display_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int AW      = 8,
    parameter int DW      = DISPLAY_DW,
    parameter int TIMEOUT = DISPLAY_TIMEOUT
) (
    input  logic               c125,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_timeout,
    output logic               link_valid,
    output logic               link_write,
    output logic [AW-1:0]      link_addr,
    output logic [DW-1:0]      link_wdata,
    input  logic               link_ready,
    input  logic               link_rvalid,
    input  logic [DW-1:0]      link_rdata,
    output logic               busy
);

    localparam int IW = idx_width(NREQ);
    localparam int CW = cnt_width(TIMEOUT);

    link_state_e   state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          timeout_q, timeout_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_index;
    logic            grant;
    logic            cnt_hit;

    display_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .index  (pick_index)
    );

    // No grant while reset is held, so nothing is accepted that the
    // reset edge would immediately discard.
    assign grant   = (state_q == ST_IDLE) && reset && (|pick_onehot);

    // This WAIT_RD cycle is the TIMEOUT-th one.
    assign cnt_hit = (cnt_q == CW'(TIMEOUT - 1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge c125) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge
        // values and the evaluation order of always blocks cannot matter.
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (grant) state_d = ST_ISSUE;
            ST_ISSUE:   if (link_ready) state_d = write_q ? ST_RESP : ST_WAIT_RD;
            ST_WAIT_RD: if (link_rvalid || cnt_hit) state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers: pointer, wait counter, captured command, result
    // -----------------------------------------------------------------------
    always_ff @(posedge c125) begin
        // NOTE: the capture registers are reset as well as the control
        // state; there is no storage array here, and zeroing them keeps
        // every output deterministic straight out of reset.
        if (!reset) begin
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        rr_ptr_d  = rr_ptr_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        write_d   = write_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    rr_ptr_d  = (pick_index == IW'(NREQ - 1)) ? '0 : pick_index + 1'b1;
                    idx_d     = pick_index;
                    write_d   = req_write[pick_index];
                    addr_d    = req_addr[pick_index*AW +: AW];
                    wdata_d   = req_wdata[pick_index*DW +: DW];
                    // Writes complete with zero data and no timeout.
                    rdata_d   = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_ISSUE: begin
                if (link_ready) cnt_d = '0;
            end
            ST_WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                // Returned data takes priority over a coincident timeout.
                if (link_rvalid) begin
                    rdata_d   = link_rdata;
                    timeout_d = 1'b0;
                end else if (cnt_hit) begin
                    rdata_d   = '1;
                    timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from state so each one is zero outside its phase
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_rdata   = '0;
        rsp_timeout = 1'b0;
        link_valid  = 1'b0;
        link_write  = 1'b0;
        link_addr   = '0;
        link_wdata  = '0;
        busy        = (state_q != ST_IDLE);
        unique case (state_q)
            ST_IDLE: begin
                if (grant) req_ready = pick_onehot;
            end
            ST_ISSUE: begin
                link_valid = 1'b1;
                link_write = write_q;
                link_addr  = addr_q;
                link_wdata = wdata_q;
            end
            ST_RESP: begin
                rsp_valid[idx_q] = 1'b1;
                rsp_rdata        = rdata_q;
                rsp_timeout      = timeout_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_display_link_arbiter.sv
// ---------------------------------------------------------------------------
// tb_display_link_arbiter
// Directed bench for display_link_arbiter. A transaction-level reference
// model predicts every output each cycle; the directed sequence adds
// hand-computed expectations at the interesting cycles.
// ---------------------------------------------------------------------------
module tb_display_link_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 8;
    localparam int DW      = 32;
    localparam int TIMEOUT = 255;

    logic               c125 = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid, req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]      rsp_rdata;
    logic               rsp_timeout;
    logic               link_valid, link_write;
    logic [AW-1:0]      link_addr;
    logic [DW-1:0]      link_wdata;
    logic               link_ready, link_rvalid;
    logic [DW-1:0]      link_rdata;
    logic               busy;

    int checks   = 0;
    int failures = 0;

    always #5 c125 = ~c125;

    display_link_arbiter #(
        .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .c125        (c125),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .link_valid  (link_valid),
        .link_write  (link_write),
        .link_addr   (link_addr),
        .link_wdata  (link_wdata),
        .link_ready  (link_ready),
        .link_rvalid (link_rvalid),
        .link_rdata  (link_rdata),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: one outstanding transaction described as a record
    // plus progress flags; expected outputs follow from which flags are set.
    // -----------------------------------------------------------------------
    typedef struct {
        int            idx;
        bit            write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } txn_t;

    bit            m_active, m_sent, m_done, m_to;
    int            m_ptr, m_waited, m_win;
    txn_t          m_txn;
    logic [DW-1:0] m_rdata;

    logic [NREQ-1:0] e_ready, e_rsp;
    logic [DW-1:0]   e_rdata, e_lwd;
    logic [AW-1:0]   e_la;
    logic            e_to, e_lv, e_lw, e_busy;

    initial begin
        m_active = 0; m_sent = 0; m_done = 0; m_to = 0;
        m_ptr = 0; m_waited = 0; m_rdata = '0;
        m_txn = '{idx: 0, write: 0, addr: '0, wdata: '0};
        // Outputs are only defined once the first reset edge has been seen.
        do @(posedge c125); while (reset !== 1'b0);
        forever begin
            @(negedge c125);
            e_ready = '0; e_rsp = '0; e_rdata = '0; e_to = 0;
            e_lv = 0; e_lw = 0; e_la = '0; e_lwd = '0;
            e_busy = m_active;
            m_win = -1;
            if (!m_active) begin
                if (reset) begin
                    for (int k = 0; k < NREQ; k++)
                        if (m_win < 0 && req_valid[(m_ptr + k) % NREQ]) m_win = (m_ptr + k) % NREQ;
                end
                if (m_win >= 0) e_ready[m_win] = 1'b1;
            end else if (!m_sent) begin
                e_lv = 1; e_lw = m_txn.write; e_la = m_txn.addr; e_lwd = m_txn.wdata;
            end else if (m_done) begin
                e_rsp[m_txn.idx] = 1'b1; e_rdata = m_rdata; e_to = m_to;
            end

            check("m_req_ready",   req_ready,   e_ready);
            check("m_rsp_valid",   rsp_valid,   e_rsp);
            check("m_rsp_rdata",   rsp_rdata,   e_rdata);
            check("m_rsp_timeout", rsp_timeout, e_to);
            check("m_link_valid",  link_valid,  e_lv);
            check("m_link_write",  link_write,  e_lw);
            check("m_link_addr",   link_addr,   e_la);
            check("m_link_wdata",  link_wdata,  e_lwd);
            check("m_busy",        busy,        e_busy);

            // Advance to what the coming clock edge produces.
            if (!reset) begin
                m_active = 0; m_sent = 0; m_done = 0; m_ptr = 0; m_waited = 0;
            end else if (!m_active) begin
                if (m_win >= 0) begin
                    m_active = 1; m_sent = 0; m_done = 0; m_waited = 0;
                    m_txn.idx   = m_win;
                    m_txn.write = req_write[m_win];
                    m_txn.addr  = req_addr[m_win*AW +: AW];
                    m_txn.wdata = req_wdata[m_win*DW +: DW];
                    m_ptr = (m_win + 1) % NREQ;
                end
            end else if (!m_sent) begin
                if (link_ready) begin
                    m_sent = 1;
                    if (m_txn.write) begin m_done = 1; m_rdata = '0; m_to = 0; end
                end
            end else if (m_done) begin
                m_active = 0; m_sent = 0; m_done = 0;
            end else begin
                m_waited++;
                if (link_rvalid) begin
                    m_done = 1; m_rdata = link_rdata; m_to = 0;
                end else if (m_waited == TIMEOUT) begin
                    m_done = 1; m_rdata = '1; m_to = 1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge,
    // outputs are sampled on the falling edge.
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge c125);
        #1;
    endtask

    task automatic sample();
        @(negedge c125);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        link_ready = 1'b0; link_rvalid = 1'b0; link_rdata = '0;
    endtask

    task automatic set_req(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 600; n++) begin
            step();
            sample();
            if (busy === 1'b0) break;
        end
        check(name, busy, 1'b0);
    endtask

    function automatic int low_index(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    int grants [5];
    int ngrant;
    int waits;
    bit got;

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got 0 expected 1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        idle_inputs();
        reset = 1'b0;

        // ---- reset state ----
        repeat (2) step();
        sample();
        check("rst_req_ready",  req_ready,  4'b0000);
        check("rst_rsp_valid",  rsp_valid,  4'b0000);
        check("rst_link_valid", link_valid, 1'b0);
        check("rst_link_addr",  link_addr,  8'h00);
        check("rst_busy",       busy,       1'b0);
        step();
        reset = 1'b1;
        sample();

        // ---- round-robin: all four writing continuously ----
        step();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(8'h40 + i), DW'(32'hA000_0000 + i));
        link_ready = 1'b1;
        ngrant = 0;
        for (int n = 0; n < 40; n++) begin
            sample();
            if (req_ready != '0) begin
                grants[ngrant] = low_index(req_ready);
                ngrant++;
            end
            if (ngrant == 5) break;
            step();
        end
        check("rr_grant_count", ngrant, 5);
        check("rr_grant0", grants[0], 0);
        check("rr_grant1", grants[1], 1);
        check("rr_grant2", grants[2], 2);
        check("rr_grant3", grants[3], 3);
        check("rr_grant4", grants[4], 0);
        for (int i = 1; i < 5; i++) check("rr_no_repeat", grants[i] == grants[i-1], 1'b0);
        step();
        req_valid = '0;
        wait_idle("rr_idle");

        // ---- single write, minimum latency ----
        step();
        idle_inputs();
        set_req(2, 1'b1, 8'h10, 32'hDEAD_BEEF);
        link_ready = 1'b1;
        sample();
        check("wr_c0_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        sample();
        check("wr_c1_link_valid", link_valid, 1'b1);
        check("wr_c1_link_write", link_write, 1'b1);
        check("wr_c1_link_addr",  link_addr,  8'h10);
        check("wr_c1_link_wdata", link_wdata, 32'hDEAD_BEEF);
        step();
        sample();
        check("wr_c2_rsp_valid", rsp_valid, 4'b0100);
        check("wr_c2_rsp_rdata", rsp_rdata, 32'h0);
        step();
        set_req(0, 1'b1, 8'h11, 32'h0000_0001);
        sample();
        check("wr_c3_accept", req_ready, 4'b0001);
        step();
        req_valid = '0;
        wait_idle("wr_idle");

        // ---- read, data after 5 wait cycles; rvalid during ISSUE ignored ----
        step();
        idle_inputs();
        set_req(1, 1'b0, 8'h20, 32'h0);
        link_ready = 1'b1;
        sample();
        check("rd_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        link_rvalid = 1'b1;
        link_rdata  = 32'hBAD0_BAD0;
        sample();
        check("rd_link_addr",  link_addr,  8'h20);
        check("rd_link_write", link_write, 1'b0);
        for (int n = 0; n < 5; n++) begin
            step();
            link_rvalid = 1'b0;
            sample();
            check("rd_wait_quiet", rsp_valid, 4'b0000);
        end
        step();
        link_rvalid = 1'b1;
        link_rdata  = 32'h1234_5678;
        sample();
        step();
        link_rvalid = 1'b0;
        link_rdata  = '0;
        sample();
        check("rd_rsp_valid",   rsp_valid,   4'b0010);
        check("rd_rsp_rdata",   rsp_rdata,   32'h1234_5678);
        check("rd_rsp_timeout", rsp_timeout, 1'b0);
        wait_idle("rd_idle");

        // ---- read timeout ----
        step();
        idle_inputs();
        set_req(0, 1'b0, 8'h30, 32'h0);
        link_ready = 1'b1;
        sample();
        check("to_ready", req_ready, 4'b0001);
        step();
        req_valid = '0;
        sample();
        waits = 0;
        got   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            step();
            sample();
            if (rsp_valid != '0) begin
                got = 1'b1;
                break;
            end
            waits++;
        end
        check("to_seen",        got,         1'b1);
        check("to_wait_cycles", waits,       255);
        check("to_rsp_valid",   rsp_valid,   4'b0001);
        check("to_rsp_rdata",   rsp_rdata,   32'hFFFF_FFFF);
        check("to_rsp_timeout", rsp_timeout, 1'b1);
        wait_idle("to_idle");

        // ---- data arriving on the last wait cycle beats the timeout ----
        step();
        idle_inputs();
        set_req(3, 1'b0, 8'h31, 32'h0);
        link_ready = 1'b1;
        sample();
        check("race_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        sample();
        for (int n = 0; n < TIMEOUT - 1; n++) begin
            step();
            sample();
        end
        step();
        link_rvalid = 1'b1;
        link_rdata  = 32'h5A5A_5A5A;
        sample();
        check("race_last_wait", rsp_valid, 4'b0000);
        step();
        link_rvalid = 1'b0;
        sample();
        check("race_rsp_valid",   rsp_valid,   4'b1000);
        check("race_rsp_rdata",   rsp_rdata,   32'h5A5A_5A5A);
        check("race_rsp_timeout", rsp_timeout, 1'b0);
        wait_idle("race_idle");

        // ---- backpressure: link_ready low for 10 cycles ----
        step();
        idle_inputs();
        set_req(3, 1'b1, 8'h55, 32'hCAFE_F00D);
        sample();
        check("bp_ready", req_ready, 4'b1000);
        step();
        req_valid = '0;
        req_valid[0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) step();
            sample();
            check("bp_link_valid", link_valid, 1'b1);
            check("bp_link_write", link_write, 1'b1);
            check("bp_link_addr",  link_addr,  8'h55);
            check("bp_link_wdata", link_wdata, 32'hCAFE_F00D);
            check("bp_no_rsp",     rsp_valid,  4'b0000);
            check("bp_no_accept",  req_ready,  4'b0000);
        end
        step();
        req_valid  = '0;
        link_ready = 1'b1;
        sample();
        step();
        sample();
        check("bp_rsp_valid", rsp_valid, 4'b1000);
        wait_idle("bp_idle");

        // ---- reset during WAIT_RD abandons the read ----
        step();
        idle_inputs();
        set_req(2, 1'b0, 8'h66, 32'h0);
        link_ready = 1'b1;
        sample();
        check("rw_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        sample();
        repeat (2) begin
            step();
            sample();
        end
        step();
        reset = 1'b0;
        sample();
        step();
        reset = 1'b1;
        sample();
        check("rw_req_ready",   req_ready,   4'b0000);
        check("rw_rsp_valid",   rsp_valid,   4'b0000);
        check("rw_rsp_rdata",   rsp_rdata,   32'h0);
        check("rw_rsp_timeout", rsp_timeout, 1'b0);
        check("rw_link_valid",  link_valid,  1'b0);
        check("rw_link_write",  link_write,  1'b0);
        check("rw_link_addr",   link_addr,   8'h00);
        check("rw_link_wdata",  link_wdata,  32'h0);
        check("rw_busy",        busy,        1'b0);
        for (int n = 0; n < 20; n++) begin
            step();
            link_rvalid = (n == 3);
            link_rdata  = 32'h7777_7777;
            sample();
            check("rw_no_rsp", rsp_valid, 4'b0000);
        end
        step();
        link_rvalid = 1'b0;
        set_req(1, 1'b1, 8'h01, 32'h1);
        set_req(3, 1'b1, 8'h03, 32'h3);
        sample();
        check("rw_ptr_cleared", req_ready, 4'b0010);
        step();
        req_valid = '0;
        wait_idle("rw_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
